// File: rtl/keypad_debounce_repeat.sv
// Keypad debouncer with press/release debouncing, typematic auto-repeat and
// long-press detection for a single latched key code.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_detected   : scanner reports a key present
//   key_code       : decoded code, meaningful only while key_detected=1
//   press_pulse    : one cycle when a press is accepted
//   repeat_pulse   : one cycle per auto-repeat event
//   release_pulse  : one cycle when a release is accepted
//   key_out        : latched code (0 while idle or debouncing a press)
//   key_held       : key accepted and not yet released
//   long_held      : first repeat has fired, until release
//   scan_stop      : freeze scanner on the current key while not idle
module keypad_debounce_repeat #(
  parameter int unsigned KEY_W        = 4,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DEBOUNCE_CYC = 60000,
  parameter int unsigned RELEASE_CYC  = 60000,
  parameter int unsigned HOLD_CYC     = 300000,
  parameter int unsigned REPEAT_CYC   = 150000,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_detected,
  input  logic [KEY_W-1:0] key_code,
  output logic             press_pulse,
  output logic             repeat_pulse,
  output logic             release_pulse,
  output logic [KEY_W-1:0] key_out,
  output logic             key_held,
  output logic             long_held,
  output logic             scan_stop
);

  localparam logic [63:0] CNT_SPAN = 64'd1 << CNT_W;

  // Reject cycle counts the counters cannot reach or that break pulse spacing.
  if (DEBOUNCE_CYC < 1 || RELEASE_CYC < 1 || HOLD_CYC < 2 || REPEAT_CYC < 2 ||
      64'(DEBOUNCE_CYC) > CNT_SPAN || 64'(RELEASE_CYC) > CNT_SPAN ||
      64'(HOLD_CYC) > CNT_SPAN || 64'(REPEAT_CYC) > CNT_SPAN) begin : g_param_check
    $error("keypad_debounce_repeat: cycle parameter out of range for CNT_W");
  end

  // Terminal compare values; counters clear on these so they never wrap.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_next;
  logic             first_done, first_done_next;
  logic [KEY_W-1:0] latch, latch_next;

  logic             press_next, repeat_next, release_next;
  logic [KEY_W-1:0] key_out_next;
  logic             key_held_next, long_held_next, scan_stop_next;

  logic             present;

  // A different code counts as absent so a rolled-over key looks like a release.
  assign present = key_detected && (key_code == latch);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rpt_cnt       <= '0;
      first_done    <= 1'b0;
      latch         <= '0;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      key_out       <= '0;
      key_held      <= 1'b0;
      long_held     <= 1'b0;
      scan_stop     <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      rpt_cnt       <= rpt_cnt_next;
      first_done    <= first_done_next;
      latch         <= latch_next;
      press_pulse   <= press_next;
      repeat_pulse  <= repeat_next;
      release_pulse <= release_next;
      key_out       <= key_out_next;
      key_held      <= key_held_next;
      long_held     <= long_held_next;
      scan_stop     <= scan_stop_next;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    rpt_cnt_next    = rpt_cnt;
    first_done_next = first_done;
    latch_next      = latch;
    press_next      = 1'b0;
    repeat_next     = 1'b0;
    release_next    = 1'b0;

    case (state)
      IDLE: begin
        if (key_detected) begin
          latch_next = key_code;
          cnt_next   = '0;
          state_next = PRESS_DB;
        end
      end

      PRESS_DB: begin
        if (!present) begin
          state_next = IDLE;
        end else if (cnt == DB_LAST) begin
          state_next      = HELD;
          press_next      = 1'b1;
          rpt_cnt_next    = '0;
          first_done_next = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      HELD: begin
        // rpt_cnt/first_done stay frozen on leaving so a release bounce resumes cadence.
        if (!present) begin
          state_next = RELEASE_DB;
          cnt_next   = '0;
        end else if (REPEAT_EN) begin
          if (!first_done && rpt_cnt == HOLD_LAST) begin
            repeat_next     = 1'b1;
            rpt_cnt_next    = '0;
            first_done_next = 1'b1;
          end else if (first_done && rpt_cnt == RPT_LAST) begin
            repeat_next  = 1'b1;
            rpt_cnt_next = '0;
          end else begin
            rpt_cnt_next = rpt_cnt + CNT_W'(1);
          end
        end
      end

      RELEASE_DB: begin
        if (present) begin
          state_next = HELD;
        end else if (cnt == REL_LAST) begin
          state_next      = IDLE;
          release_next    = 1'b1;
          latch_next      = '0;
          first_done_next = 1'b0;
          rpt_cnt_next    = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase

    // key_out/key_held still show the key during the release_pulse cycle.
    key_held_next  = (state_next == HELD) || (state_next == RELEASE_DB) || release_next;
    key_out_next   = key_held_next ? latch : '0;
    long_held_next = first_done_next & REPEAT_EN;
    scan_stop_next = (state_next != IDLE);
  end

endmodule
